// File: rtl/signed_sum_accumulator_pkg.sv
// Shared types and constants for the signed sum accumulator and its saturating adder.
package signed_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/signed_sum_accumulator_sat_add.sv
// Combinational two's-complement adder that clamps to the signed rails on overflow.
module sat_add #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    sat
);

    // Overflow only when both operands share a sign and the wrapped result flips it.
    function automatic logic [WIDTH:0] saturate(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] s;
        logic                    ovf;
        s   = x + y;
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        if (ovf && !x[WIDTH-1]) begin
            s = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (ovf) begin
            s = {1'b1, {(WIDTH-1){1'b0}}};
        end
        return {ovf, s};
    endfunction

    always_comb begin
        {sat, sum} = saturate(a, b);
    end

endmodule

// File: rtl/signed_sum_accumulator.sv
// Accumulates a programmed number of signed sums with saturation and hands the total downstream.
module signed_sum_accumulator
    import signed_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_ovf,
    output logic                    busy
);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    ovf_q, ovf_d;
    logic signed [WIDTH-1:0] add_sum;
    logic                    add_sat;
    logic [LEN_W-1:0]        cnt_inc;

    sat_add #(.WIDTH(WIDTH)) u_sat_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_sat;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // start arriving together with out_ready is deliberately dropped.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register stage: reset has priority over clear, clear over normal operation.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Randomized self-checking bench for signed_sum_accumulator against a clamp-at-the-rails integer model.
module tb_signed_sum_accumulator;

    logic               clk = 1'b0;
    logic               rst_n, start, clear, in_valid, out_ready;
    logic [7:0]         len;
    logic signed [31:0] in_data;
    logic               in_ready, out_valid, out_ovf, busy;
    logic signed [31:0] out_data;

    int vectors = 0;
    int miscompares = 0;

    signed_sum_accumulator #(.WIDTH(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum, clamped to the 32-bit signed range after every term.
    function automatic void model(input logic signed [31:0] t[$],
                                  output logic signed [31:0] tot, output logic ov);
        longint a;
        a  = 0;
        ov = 1'b0;
        foreach (t[i]) begin
            a = a + longint'(t[i]);
            if (a > 64'sd2147483647) begin
                a  = 64'sd2147483647;
                ov = 1'b1;
            end else if (a < -64'sd2147483648) begin
                a  = -64'sd2147483648;
                ov = 1'b1;
            end
        end
        tot = 32'(a);
    endfunction

    // Drives one run; reports whether in_ready was seen at every offer and out_valid right after the last term.
    task automatic run(input int l, input logic signed [31:0] terms[$], input int maxgap,
                       output logic rdy_ok, output logic vld_ok,
                       output logic signed [31:0] d, output logic o);
        logic [31:0] lv;
        lv    = l;
        start = 1'b1;
        len   = lv[7:0];
        tick();
        start  = 1'b0;
        len    = 8'($urandom);
        rdy_ok = 1'b1;
        foreach (terms[i]) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
            in_valid = 1'b1;
            in_data  = terms[i];
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        vld_ok   = (out_valid === 1'b1) && (in_ready === 1'b0) && (busy === 1'b1);
        d        = out_data;
        o        = out_ovf;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0 || out_data !== 32'sd0) begin
            miscompares++;
            $display("FAIL reset: rdy/vld/busy/ovf=%b data=%h, required 0000 / 00000000",
                     {in_ready, out_valid, busy, out_ovf}, out_data);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b vld=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic signed [31:0] q[$];
        logic rok, vok, o;
        logic signed [31:0] d;
        q = '{32'sd5, -32'sd2, 32'sd10};
        run(3, q, 0, rok, vok, d, o);
        vectors++;
        if (!rok || !vok) begin
            miscompares++;
            $display("FAIL basic_handshake: rdy_ok=%b vld_ok=%b, required 1 1", rok, vok);
        end
        vectors++;
        if (d !== 32'sd13 || o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_sum: data=%0d ovf=%b, required 13 0", d, o);
        end
        release_result();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: vld=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] q[$];
        logic rok, vok, o;
        logic signed [31:0] d;
        q = '{32'sh7FFF_FFF0, 32'sh0000_0020};
        run(2, q, 1, rok, vok, d, o);
        vectors++;
        if (!vok || d !== 32'sh7FFF_FFFF || o !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_pos: vld_ok=%b data=%h ovf=%b, required 1 7fffffff 1", vok, d, o);
        end
        release_result();
        q = '{32'sh8000_0010, -32'sh0000_0020};
        run(2, q, 1, rok, vok, d, o);
        vectors++;
        if (!vok || d !== 32'sh8000_0000 || o !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_neg: vld_ok=%b data=%h ovf=%b, required 1 80000000 1", vok, d, o);
        end
        release_result();
        q = '{32'sh7FFF_FFFF, 32'sd1, -32'sd5};
        run(3, q, 0, rok, vok, d, o);
        vectors++;
        if (!vok || d !== 32'sh7FFF_FFFA || o !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_continue: vld_ok=%b data=%h ovf=%b, required 1 7ffffffa 1", vok, d, o);
        end
        release_result();
    endtask

    task automatic test_len_zero();
        logic signed [31:0] q[$];
        logic rok, vok, o;
        logic signed [31:0] d;
        q = {};
        run(0, q, 0, rok, vok, d, o);
        vectors++;
        if (!vok || d !== 32'sd0 || o !== 1'b0) begin
            miscompares++;
            $display("FAIL len_zero: vld_ok=%b data=%h ovf=%b, required 1 00000000 0", vok, d, o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'sd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL len_zero_hold%0d: vld=%b data=%h ovf=%b rdy=%b, required 1 00000000 0 0",
                         c, out_valid, out_data, out_ovf, in_ready);
            end
        end
        release_result();
    endtask

    task automatic test_clear();
        logic signed [31:0] q[$];
        logic rok, vok, o;
        logic signed [31:0] d;
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b0;
            tick();
            in_valid = 1'b1;
            in_data  = 32'sd100 + i;
            tick();
        end
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'sd0) begin
            miscompares++;
            $display("FAIL clear: busy=%b rdy=%b vld=%b data=%h, required 0 0 0 00000000",
                     busy, in_ready, out_valid, out_data);
        end
        q = '{-32'sd7};
        run(1, q, 0, rok, vok, d, o);
        vectors++;
        if (!vok || d !== 32'shFFFF_FFF9 || o !== 1'b0) begin
            miscompares++;
            $display("FAIL after_clear: vld_ok=%b data=%h ovf=%b, required 1 fffffff9 0", vok, d, o);
        end
        release_result();
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        len   = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'sh7FFF_FFFF;
        tick();
        in_data  = 32'sd9;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        vectors++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0 || out_data !== 32'sd0) begin
            miscompares++;
            $display("FAIL mid_reset: rdy/vld/busy/ovf=%b data=%h, required 0000 00000000",
                     {in_ready, out_valid, busy, out_ovf}, out_data);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        len   = 8'd2;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        len   = 8'd5;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'sd3;
        tick();
        in_data = 32'sd4;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'sd7) begin
            miscompares++;
            $display("FAIL start_in_accum: vld=%b data=%0d, required 1 7", out_valid, out_data);
        end
        start = 1'b1;
        len   = 8'd6;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'sd7 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: vld=%b data=%0d rdy=%b, required 1 7 0", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_with_ready: busy=%b vld=%b rdy=%b, required 0 0 0", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            logic signed [31:0] q[$];
            logic signed [31:0] etot, d;
            logic eov, rok, vok, o;
            int l, w;
            l = (r == 0) ? 255 : int'($urandom_range(8, 1));
            q = {};
            for (int i = 0; i < l; i++) begin
                case ((r == 0) ? 0 : $urandom_range(3, 0))
                    0: q.push_back(32'($signed(12'($urandom))));
                    1: q.push_back($urandom);
                    2: q.push_back(32'sh7FFF_0000 + 32'($urandom_range(65535, 0)));
                    default: q.push_back(32'sh8000_0000 + 32'($urandom_range(65535, 0)));
                endcase
            end
            model(q, etot, eov);
            run(l, q, (r == 0) ? 0 : 2, rok, vok, d, o);
            vectors++;
            if (!rok || !vok || d !== etot || o !== eov) begin
                miscompares++;
                $display("FAIL random%0d len=%0d: rdy_ok=%b vld_ok=%b data=%h ovf=%b, required 1 1 %h %b",
                         r, l, rok, vok, d, o, etot, eov);
            end
            w = $urandom_range(3, 0);
            for (int c = 0; c < w; c++) begin
                tick();
                vectors++;
                if (out_valid !== 1'b1 || out_data !== etot || out_ovf !== eov) begin
                    miscompares++;
                    $display("FAIL random%0d_hold: vld=%b data=%h ovf=%b, required 1 %h %b",
                             r, out_valid, out_data, out_ovf, etot, eov);
                end
            end
            release_result();
            vectors++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL random%0d_release: busy=%b vld=%b, required 0 0", r, busy, out_valid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'sd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_len_zero();
        test_clear();
        test_mid_reset();
        test_start_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signed_sum_accumulator.md
Name: signed_sum_accumulator

Overview:
- Downstream consumer of the 32-bit signed two's-complement adder stage.
- Accepts a stream of signed sums over a valid/ready handshake and accumulates a programmed number of terms with saturating arithmetic.
- Presents the final total, plus a sticky overflow flag, on an output valid/ready handshake.
- Sits between the adder and the result/writeback logic.

Parameters:
- WIDTH, 32, data width of input sums and of the accumulator (signed two's complement).
- LEN_W, 8, width of the term-count field; max run length is 2^LEN_W-1.

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
- len  in  LEN_W  number of terms for the run, sampled on accepted start
- clear  in  1  synchronous abort; same effect as reset on state/outputs
- in_valid  in  1  input sum valid
- in_ready  out  1  block can accept a sum this cycle
- in_data  in  WIDTH  signed sum from adder stage
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  signed accumulated total
- out_ovf  out  1  at least one saturation occurred during the run
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; acc=0, cnt=0, len_q=0, ovf=0.
  - in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
- clear=1 at a clk edge: identical to reset. rst_n has priority, then clear, over any other event in the same cycle.
- States:
  - IDLE: start=1 -> latch len_q=len, acc=0, cnt=0, ovf=0.
    - len!=0 -> ACCUM.
    - len==0 -> DONE (out_data=0, out_ovf=0 next cycle).
  - ACCUM: in_ready=1.
    - On in_valid&in_ready: acc <= sat_add(acc, in_data), cnt <= cnt+1, ovf <= ovf|sat.
    - If cnt+1==len_q -> DONE the same edge; the final sum is visible on out_data with out_valid=1 the next cycle (one-cycle latency from last accepted term).
    - in_valid=0: hold everything, no timeout.
  - DONE: in_ready=0, out_valid=1; out_data=acc, out_ovf=ovf held stable until out_ready=1.
    - On out_valid&out_ready -> IDLE, out_valid=0 next cycle.
- in_ready is 0 in IDLE and DONE. Data offered then is not consumed and must be held by the producer.
- start outside IDLE is ignored. start and out_ready in the same DONE cycle: return to IDLE only; start is not captured.
- Saturating add:
  - Full-width sum s=a+b.
  - Overflow iff a and b have the same sign bit and s sign differs.
  - Positive overflow -> 0x7FFF_FFFF; negative overflow -> 0x8000_0000; sat=1.
  - Later terms continue to add from the saturated value (no latching at the rail).
- cnt is LEN_W bits and never wraps, since termination occurs at len_q ≤ 2^LEN_W-1.
- out_data/out_ovf are registered outputs. Values outside DONE are don't-care for checking but must equal the last acc/ovf (no X).

Decomposition:
- Package signed_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - Constants SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000.
- Sub-module sat_add: combinational, parameter WIDTH, inputs a, b, outputs sum, sat. Reusable by other datapath stages.

Test Plan:
- start len=3; sums 5, -2, 10 with in_valid continuous -> out_valid 1 cycle after third accept, out_data=13, out_ovf=0, busy low after out_ready.
- start len=2; sums 0x7FFF_FFF0, 0x20 -> out_data=0x7FFF_FFFF, out_ovf=1. Repeat with 0x8000_0010, -0x20 -> out_data=0x8000_0000, out_ovf=1.
- start len=3; sums 0x7FFF_FFFF, 1, -5 -> saturate after term 2, then out_data=0x7FFF_FFFA, out_ovf=1.
- start len=0 -> next cycle out_valid=1, out_data=0, in_ready never asserted. out_ready held low 4 cycles -> out_valid/out_data stable throughout.
- start len=4; accept 2 terms with in_valid gaps. Then:
  - clear=1 -> next cycle state IDLE, busy=0, in_ready=0.
  - New start len=1, sum -7 -> out_data=-7 (0xFFFF_FFF9), out_ovf=0.
- Mid-run rst_n=0 with in_valid=1 -> all outputs at reset values next cycle.
- Separately, start pulsed during ACCUM/DONE -> ignored, len_q unchanged.
